// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer sitting in front of uart_tx.
// Producers write at full clock rate; bytes are handed to uart_tx one at a time
// over its tx_start/data_in/busy handshake.
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    input  logic              i_ovf_clr,
    output logic              o_tx_start,
    output logic [7:0]        o_data_in,
    input  logic              i_busy
);

    localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    state_t            r_state;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_tx_start;
    logic [7:0]        r_data_in;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_pop;

    // Flags come from the registered count only, so they lag the causing edge by one.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A write while full is dropped even if a pop happens on the same edge.
    assign w_wr_ok = i_wr_en & ~w_full;
    // Never pop into a busy transmitter, whoever is driving it.
    assign w_pop   = (r_state == StIdle) & ~w_empty & ~i_busy;

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_start = r_tx_start;
    assign o_data_in  = r_data_in;

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a dropped write beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Launch sequencer with registered tx_start/data_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_tmo      <= '0;
            r_tx_start <= 1'b0;
            r_data_in  <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_data_in  <= r_mem[r_rp];
                        r_tx_start <= 1'b1;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    r_tmo   <= TMO_LOAD;
                    r_state <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (i_busy) begin
                        r_state <= StWaitDone;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                        // Transmitter never answered: treat the byte as sent.
                        if (r_tmo <= TMO_W'(1)) begin
                            r_state <= StIdle;
                        end
                    end
                end
                StWaitDone: begin
                    if (!i_busy) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
